// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute control unit for the ALU datapath.
// Optional PUSH/POP on the HALT_OP group when CTRL_STACK_EN is defined.
module ctrl_sequencer #(
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] IR_Q,
    input  logic [3:0]  ALU_Flag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic [2:0]  SeqT
);

    typedef enum logic [2:0] {
        FETCH_H = 3'd0,
        FETCH_L = 3'd1,
        EXEC1   = 3'd2,
        EXEC2   = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t      state;
    logic [3:0]  flag_q;
    logic        flag_pend;

    logic [3:0]  op;
    logic [1:0]  sub;
    logic [1:0]  rx;
    logic [1:0]  src2;
    logic [3:0]  dst;
    logic [3:0]  alu_code;
    logic        is_alu;
    logic        unused_ok;

    assign op   = IR_Q[15:12];
    assign rx   = IR_Q[11:10];
    assign sub  = IR_Q[9:8];
    assign src2 = IR_Q[7:6];
    assign dst  = ~(4'b0001 << rx);
    assign SeqT = state;
    assign is_alu = (op >= 4'h4) && (op <= 4'hB);

    // Immediate/address bits go straight to the datapath; only Z is tested here.
    assign unused_ok = ^{flag_q[3:1], IR_Q[5:0]};

    always_comb begin
        alu_code = 4'b0000;
        case (op)
            4'h4:    alu_code = 4'b0100;
            4'h5:    alu_code = 4'b0110;
            4'h6:    alu_code = 4'b0111;
            4'h7:    alu_code = 4'b1000;
            4'h8:    alu_code = 4'b1001;
            4'h9:    alu_code = 4'b0010;
            4'hA:    alu_code = 4'b1010;
            4'hB:    alu_code = 4'b1011;
            default: alu_code = 4'b0000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= FETCH_H;
            flag_q    <= 4'b0000;
            flag_pend <= 1'b0;
        end else begin
            case (state)
                FETCH_H: begin
                    if (flag_pend) begin
                        flag_q    <= ALU_Flag;
                        flag_pend <= 1'b0;
                    end
                    state <= FETCH_L;
                end
                FETCH_L: state <= EXEC1;
                EXEC1: begin
                    state <= FETCH_H;
                    if (op == HALT_OP) begin
                        if (sub == 2'b00) begin
                            state <= HALT;
                        end
`ifdef CTRL_STACK_EN
                        else if (sub == 2'b10) begin
                            state <= EXEC2;
                        end
`endif
                    end else if (op == 4'h1 || op == 4'h2) begin
                        state <= EXEC2;
                    end else if (is_alu) begin
                        flag_pend <= 1'b1;
                    end
                end
                EXEC2:   state <= FETCH_H;
                HALT:    state <= HALT;
                default: state <= FETCH_H;
            endcase
        end
    end

    always_comb begin
        RF_OutASel  = 2'b00;
        RF_OutBSel  = 2'b00;
        RF_FunSel   = 2'b00;
        RF_RegSel   = 4'b1111;
        ALU_FunSel  = 4'b0000;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 3'b111;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'b00;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;
        if (!RST_N) begin
            // Clear every register in the datapath while reset is held.
            RF_RegSel  = 4'b0000;
            ARF_RegSel = 3'b000;
            RF_FunSel  = 2'b11;
            ARF_FunSel = 2'b11;
            IR_Enable  = 1'b1;
            IR_Funsel  = 2'b11;
        end else begin
            case (state)
                FETCH_H, FETCH_L: begin
                    ARF_OutDSel = 2'b00;
                    Mem_CS      = 1'b0;
                    IR_Enable   = 1'b1;
                    IR_LH       = (state == FETCH_L);
                    IR_Funsel   = 2'b10;
                    ARF_RegSel  = 3'b110;
                    ARF_FunSel  = 2'b01;
                end
                EXEC1: begin
                    if (op == HALT_OP) begin
`ifdef CTRL_STACK_EN
                        if (sub == 2'b01) begin
                            ARF_OutDSel = 2'b11;
                            RF_OutASel  = rx;
                            MuxCSel     = 1'b1;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                            ARF_RegSel  = 3'b011;
                            ARF_FunSel  = 2'b00;
                        end else if (sub == 2'b10) begin
                            ARF_RegSel  = 3'b011;
                            ARF_FunSel  = 2'b01;
                        end
`endif
                    end else begin
                        case (op)
                            4'h0: begin
                                MuxASel   = 2'b00;
                                RF_RegSel = dst;
                                RF_FunSel = 2'b10;
                            end
                            4'h1, 4'h2: begin
                                MuxBSel    = 2'b01;
                                ARF_RegSel = 3'b101;
                                ARF_FunSel = 2'b10;
                            end
                            4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                            4'h8, 4'h9, 4'hA, 4'hB: begin
                                RF_OutASel = sub;
                                if (op >= 4'h4 && op <= 4'h8) begin
                                    RF_OutBSel = src2;
                                end
                                MuxCSel    = 1'b1;
                                ALU_FunSel = alu_code;
                                MuxASel    = 2'b11;
                                RF_RegSel  = dst;
                                RF_FunSel  = 2'b10;
                            end
                            4'hC, 4'hD, 4'hE: begin
                                if (op == 4'hC ||
                                    (op == 4'hD && flag_q[0]) ||
                                    (op == 4'hE && !flag_q[0])) begin
                                    MuxBSel    = 2'b01;
                                    ARF_RegSel = 3'b110;
                                    ARF_FunSel = 2'b10;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                EXEC2: begin
`ifdef CTRL_STACK_EN
                    if (op == HALT_OP) begin
                        ARF_OutDSel = 2'b11;
                        Mem_CS      = 1'b0;
                        MuxASel     = 2'b01;
                        RF_RegSel   = dst;
                        RF_FunSel   = 2'b10;
                    end else
`endif
                    if (op == 4'h1) begin
                        ARF_OutDSel = 2'b10;
                        Mem_CS      = 1'b0;
                        MuxASel     = 2'b01;
                        RF_RegSel   = dst;
                        RF_FunSel   = 2'b10;
                    end else if (op == 4'h2) begin
                        ARF_OutDSel = 2'b10;
                        RF_OutASel  = rx;
                        MuxCSel     = 1'b1;
                        ALU_FunSel  = 4'b0000;
                        Mem_CS      = 1'b0;
                        Mem_WR      = 1'b1;
                    end
                end
                HALT:    Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
